// File: rtl/mips_single_cycle_core.sv
// Single-cycle MIPS-I subset core: PC/fetch unit, 32x32 register file,
// ALU, control and byte-array memories; one instruction commits per clock.
// Ports: clk (posedge), rst_n (async active-low), pc (address executing).

// Byte-wide storage presenting big-endian 32-bit words; addressed by word.
module mips_byte_mem #(
    parameter int BYTES = 1024,
    parameter int AW    = $clog2(BYTES)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-3:0] waddr,
    input  logic [31:0]   wdata,
    input  logic [AW-3:0] raddr,
    output logic [31:0]   rdata
);
    logic [7:0] bytes [0:BYTES-1];

    assign rdata = {bytes[{raddr, 2'd0}], bytes[{raddr, 2'd1}],
                    bytes[{raddr, 2'd2}], bytes[{raddr, 2'd3}]};

    // Contents are never reset; programs and data are preloaded.
    always_ff @(posedge clk) begin
        if (we) begin
            bytes[{waddr, 2'd0}] <= wdata[31:24];
            bytes[{waddr, 2'd1}] <= wdata[23:16];
            bytes[{waddr, 2'd2}] <= wdata[15:8];
            bytes[{waddr, 2'd3}] <= wdata[7:0];
        end
    end
endmodule

// Read-only instruction memory wrapper around a byte store.
module mips_imem #(
    parameter int BYTES = 1024,
    parameter int AW    = $clog2(BYTES)
) (
    input  logic          clk,
    input  logic [AW-3:0] addr,
    output logic [31:0]   instr
);
    mips_byte_mem #(.BYTES(BYTES), .AW(AW)) storage (
        .clk   (clk),
        .we    (1'b0),
        .waddr ('0),
        .wdata ('0),
        .raddr (addr),
        .rdata (instr)
    );
endmodule

// Program counter register plus combinational fetch.
module mips_ifu #(
    parameter int IMEM_BYTES = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] next_pc,
    output logic [31:0] pc,
    output logic [31:0] instr
);
    localparam int IAW = $clog2(IMEM_BYTES);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pc <= '0;
        else        pc <= next_pc;
    end

    // Upper PC bits are dropped so fetch wraps modulo memory size.
    mips_imem #(.BYTES(IMEM_BYTES), .AW(IAW)) imemory (
        .clk   (clk),
        .addr  (pc[IAW-1:2]),
        .instr (instr)
    );
endmodule

// 32x32 register file, two combinational reads, $0 hardwired to zero.
module mips_regfile (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        we,
    input  logic [4:0]  waddr,
    input  logic [31:0] wdata,
    input  logic [4:0]  ra1,
    input  logic [4:0]  ra2,
    output logic [31:0] rd1,
    output logic [31:0] rd2
);
    logic [31:0] registers [0:31];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) registers[i] <= '0;
        end else if (we && waddr != 5'd0) begin
            registers[waddr] <= wdata;
        end
    end

    assign rd1 = (ra1 == 5'd0) ? '0 : registers[ra1];
    assign rd2 = (ra2 == 5'd0) ? '0 : registers[ra2];
endmodule

module mips_single_cycle_core #(
    parameter int IMEM_BYTES = 1024,
    parameter int DMEM_BYTES = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] pc
);
    localparam int DAW = $clog2(DMEM_BYTES);

    localparam logic [5:0] OP_R     = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLTU = 6'h2B;

    logic [31:0] instr;
    logic [31:0] next_pc;
    logic [31:0] pc_plus4;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic [31:0] simm;
    logic [31:0] zimm;
    logic [31:0] result;
    logic [31:0] mem_rdata;
    logic [5:0]  op;
    logic [5:0]  funct;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [25:0] target;
    logic [4:0]  waddr;
    logic        reg_we;
    logic        mem_we;
    logic [DAW-1:2] dm_word;
    logic [1:0]     dm_unused_lo;

    mips_ifu #(.IMEM_BYTES(IMEM_BYTES)) IFU (
        .clk     (clk),
        .rst_n   (rst_n),
        .next_pc (next_pc),
        .pc      (pc),
        .instr   (instr)
    );

    assign op     = instr[31:26];
    assign rs     = instr[25:21];
    assign rt     = instr[20:16];
    assign rd     = instr[15:11];
    assign shamt  = instr[10:6];
    assign funct  = instr[5:0];
    assign target = instr[25:0];
    assign simm   = {{16{instr[15]}}, instr[15:0]};
    assign zimm   = {16'h0000, instr[15:0]};

    assign pc_plus4 = pc + 32'd4;

    mips_regfile registers (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (reg_we),
        .waddr (waddr),
        .wdata (result),
        .ra1   (rs),
        .ra2   (rt),
        .rd1   (rs_val),
        .rd2   (rt_val)
    );

    // Only the in-range word index of rs+imm matters; byte offset dropped.
    assign {dm_word, dm_unused_lo} = rs_val[DAW-1:0] + simm[DAW-1:0];

    // Stores are suppressed while reset is held.
    mips_byte_mem #(.BYTES(DMEM_BYTES), .AW(DAW)) dmemory (
        .clk   (clk),
        .we    (mem_we & rst_n),
        .waddr (dm_word),
        .wdata (rt_val),
        .raddr (dm_word),
        .rdata (mem_rdata)
    );

    always_comb begin
        reg_we  = 1'b0;
        mem_we  = 1'b0;
        waddr   = rt;
        result  = '0;
        next_pc = pc_plus4;
        case (op)
            OP_R: begin
                waddr  = rd;
                reg_we = 1'b1;
                case (funct)
                    FN_ADD, FN_ADDU: result = rs_val + rt_val;
                    FN_SUB, FN_SUBU: result = rs_val - rt_val;
                    FN_AND:  result = rs_val & rt_val;
                    FN_OR:   result = rs_val | rt_val;
                    FN_XOR:  result = rs_val ^ rt_val;
                    FN_NOR:  result = ~(rs_val | rt_val);
                    FN_SLT:  result = {31'b0, $signed(rs_val) < $signed(rt_val)};
                    FN_SLTU: result = {31'b0, rs_val < rt_val};
                    FN_SLL:  result = rt_val << shamt;
                    FN_SRL:  result = rt_val >> shamt;
                    FN_SRA:  result = $signed(rt_val) >>> shamt;
                    FN_JR: begin
                        reg_we  = 1'b0;
                        next_pc = rs_val;
                    end
                    default: reg_we = 1'b0;
                endcase
            end
            OP_ADDI, OP_ADDIU: begin
                reg_we = 1'b1;
                result = rs_val + simm;
            end
            OP_SLTI: begin
                reg_we = 1'b1;
                result = {31'b0, $signed(rs_val) < $signed(simm)};
            end
            OP_SLTIU: begin
                reg_we = 1'b1;
                result = {31'b0, rs_val < simm};
            end
            OP_ANDI: begin
                reg_we = 1'b1;
                result = rs_val & zimm;
            end
            OP_ORI: begin
                reg_we = 1'b1;
                result = rs_val | zimm;
            end
            OP_XORI: begin
                reg_we = 1'b1;
                result = rs_val ^ zimm;
            end
            OP_LUI: begin
                reg_we = 1'b1;
                result = {instr[15:0], 16'h0000};
            end
            OP_LW: begin
                reg_we = 1'b1;
                result = mem_rdata;
            end
            OP_SW: mem_we = 1'b1;
            OP_BEQ: begin
                if (rs_val == rt_val)
                    next_pc = pc_plus4 + {simm[29:0], 2'b00};
            end
            OP_BNE: begin
                if (rs_val != rt_val)
                    next_pc = pc_plus4 + {simm[29:0], 2'b00};
            end
            OP_J: next_pc = {pc_plus4[31:28], target, 2'b00};
            OP_JAL: begin
                next_pc = {pc_plus4[31:28], target, 2'b00};
                reg_we  = 1'b1;
                waddr   = 5'd31;
                result  = pc_plus4;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_mips_single_cycle_core.sv
// Bench for mips_single_cycle_core: directed and random programs run on an
// instruction-level model; expected state is queued and checked at negedge.
module tb_mips_single_cycle_core;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] pc;

    mips_single_cycle_core dut (
        .clk   (clk),
        .rst_n (rst_n),
        .pc    (pc)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          kind;
        int          idx;
        logic [31:0] exp;
        string       name;
    } rec_t;

    rec_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    logic [7:0]  im [0:1023];
    logic [7:0]  dm [0:1023];
    logic [31:0] rf [0:31];
    logic [31:0] m_pc;

    task automatic expect_val(int kind, int idx, logic [31:0] v, string nm);
        rec_t r;
        r.kind = kind;
        r.idx  = idx;
        r.exp  = v;
        r.name = nm;
        sb.push_back(r);
    endtask

    // Monitor: state after each commit is stable at the falling edge.
    initial begin
        rec_t r;
        logic [31:0] act;
        int b;
        forever begin
            @(negedge clk);
            while (sb.size() > 0) begin
                r = sb.pop_front();
                case (r.kind)
                    0: act = pc;
                    1: act = dut.registers.registers[r.idx];
                    default: begin
                        b = r.idx & 32'h3FC;
                        act = {dut.dmemory.bytes[b], dut.dmemory.bytes[b+1],
                               dut.dmemory.bytes[b+2], dut.dmemory.bytes[b+3]};
                    end
                endcase
                n_cmp++;
                if (act !== r.exp) begin
                    n_bad++;
                    $display("FAIL %s[%0d] @%0t: got %h want %h",
                             r.name, r.idx, $time, act, r.exp);
                end
            end
        end
    end

    function automatic logic [31:0] enc_r(int fn, int rs, int rt, int rd, int sh);
        return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'(sh), 6'(fn)};
    endfunction

    function automatic logic [31:0] enc_i(int op, int rs, int rt, int imm);
        return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
    endfunction

    function automatic logic [31:0] enc_j(int op, int tgt);
        return {6'(op), 26'(tgt)};
    endfunction

    // Reference model: executes one instruction from its own memories.
    task automatic model_step();
        int b, rs, rt, rd, sh, dst, ea;
        logic [31:0] ins, a, bv, se, ze, nxt, res;
        logic [5:0] op, fn;
        b   = int'(m_pc & 32'h3FC);
        ins = {im[b], im[b+1], im[b+2], im[b+3]};
        op  = ins[31:26];
        fn  = ins[5:0];
        rs  = int'(ins[25:21]);
        rt  = int'(ins[20:16]);
        rd  = int'(ins[15:11]);
        sh  = int'(ins[10:6]);
        a   = rf[rs];
        bv  = rf[rt];
        se  = {{16{ins[15]}}, ins[15:0]};
        ze  = {16'h0, ins[15:0]};
        nxt = m_pc + 4;
        dst = -1;
        res = 0;
        case (op)
            6'h00: case (fn)
                6'h20, 6'h21: begin dst = rd; res = a + bv; end
                6'h22, 6'h23: begin dst = rd; res = a - bv; end
                6'h24: begin dst = rd; res = a & bv; end
                6'h25: begin dst = rd; res = a | bv; end
                6'h26: begin dst = rd; res = a ^ bv; end
                6'h27: begin dst = rd; res = ~(a | bv); end
                6'h2A: begin dst = rd; res = ($signed(a) < $signed(bv)) ? 1 : 0; end
                6'h2B: begin dst = rd; res = (a < bv) ? 1 : 0; end
                6'h00: begin dst = rd; res = bv << sh; end
                6'h02: begin dst = rd; res = bv >> sh; end
                6'h03: begin
                    dst = rd;
                    res = (bv >> sh) | (bv[31] ? ~(32'hFFFF_FFFF >> sh) : 32'h0);
                end
                6'h08: nxt = a;
                default: ;
            endcase
            6'h08, 6'h09: begin dst = rt; res = a + se; end
            6'h0A: begin dst = rt; res = ($signed(a) < $signed(se)) ? 1 : 0; end
            6'h0B: begin dst = rt; res = (a < se) ? 1 : 0; end
            6'h0C: begin dst = rt; res = a & ze; end
            6'h0D: begin dst = rt; res = a | ze; end
            6'h0E: begin dst = rt; res = a ^ ze; end
            6'h0F: begin dst = rt; res = {ins[15:0], 16'h0}; end
            6'h23: begin
                ea  = int'((a + se) & 32'h3FC);
                dst = rt;
                res = {dm[ea], dm[ea+1], dm[ea+2], dm[ea+3]};
            end
            6'h2B: begin
                ea = int'((a + se) & 32'h3FC);
                {dm[ea], dm[ea+1], dm[ea+2], dm[ea+3]} = bv;
                expect_val(2, ea, bv, "store");
            end
            6'h04: if (a == bv) nxt = m_pc + 4 + (se << 2);
            6'h05: if (a != bv) nxt = m_pc + 4 + (se << 2);
            6'h02: nxt = {nxt[31:28], ins[25:0], 2'b00};
            6'h03: begin
                nxt = {nxt[31:28], ins[25:0], 2'b00};
                dst = 31;
                res = m_pc + 4;
            end
            default: ;
        endcase
        if (dst >= 0) begin
            if (dst != 0) rf[dst] = res;
            expect_val(1, dst, rf[dst], "regwr");
        end
        m_pc = nxt;
        expect_val(0, 0, m_pc, "pc");
    endtask

    task automatic run(int n);
        repeat (n) begin
            @(posedge clk);
            model_step();
        end
    endtask

    // Assert reset between edges; model state clears, data memory persists.
    task automatic assert_reset();
        @(negedge clk);
        #1 rst_n = 1'b0;
        m_pc = 0;
        for (int i = 0; i < 32; i++) rf[i] = 0;
        expect_val(0, 0, 32'h0, "rst_pc");
        for (int i = 1; i < 32; i++) expect_val(1, i, 32'h0, "rst_reg");
    endtask

    task automatic release_reset();
        @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    task automatic load_prog(input logic [31:0] p[$]);
        for (int i = 0; i < 1024; i++) begin
            im[i] = 8'h00;
            dut.IFU.imemory.storage.bytes[i] = 8'h00;
        end
        for (int w = 0; w < p.size(); w++) begin
            for (int k = 0; k < 4; k++) begin
                im[4*w+k] = p[w][31-8*k -: 8];
                dut.IFU.imemory.storage.bytes[4*w+k] = p[w][31-8*k -: 8];
            end
        end
    endtask

    function automatic logic [31:0] rand_ins();
        int k  = $urandom_range(0, 99);
        int rs = $urandom_range(0, 31);
        int rt = $urandom_range(0, 31);
        int rd = $urandom_range(0, 31);
        int sh = $urandom_range(0, 31);
        int fn;
        if (k < 35) begin
            case ($urandom_range(0, 12))
                0: fn = 'h20;  1: fn = 'h21;  2: fn = 'h22;  3: fn = 'h23;
                4: fn = 'h24;  5: fn = 'h25;  6: fn = 'h26;  7: fn = 'h27;
                8: fn = 'h2A;  9: fn = 'h2B;  10: fn = 'h00; 11: fn = 'h02;
                default: fn = 'h03;
            endcase
            return enc_r(fn, rs, rt, rd, sh);
        end
        if (k < 70)
            return enc_i(8 + $urandom_range(0, 7), rs, rt, $urandom_range(0, 65535));
        if (k < 80)
            return enc_i(($urandom_range(0, 1) != 0) ? 'h23 : 'h2B,
                         ($urandom_range(0, 3) == 0) ? rs : 0, rt,
                         4 * $urandom_range(0, 255));
        if (k < 90)
            return enc_i(($urandom_range(0, 1) != 0) ? 'h04 : 'h05, rs, rt,
                         $urandom_range(0, 8) - 3);
        if (k < 95)
            return enc_j(($urandom_range(0, 1) != 0) ? 'h02 : 'h03, $urandom_range(0, 63));
        if (k < 97)
            return enc_r('h08, 31, 0, 0, 0);
        return ($urandom_range(0, 1) != 0) ? enc_i('h3F, rs, rt, 5) : enc_r('h3F, rs, rt, rd, 0);
    endfunction

    initial begin
        logic [31:0] p[$];
        logic [7:0]  v;

        for (int i = 0; i < 1024; i++) begin
            v = 8'($urandom);
            dm[i] = v;
            dut.dmemory.bytes[i] = v;
        end

        // Fill program; reset mid-loop, then let it run to completion.
        p = '{enc_i('h0F, 0, 16, 'hFEFE), enc_i('h0D, 16, 16, 'hFEFE),
              enc_i('h08, 0, 17, 64), enc_i('h08, 0, 8, 0),
              enc_i('h2B, 8, 16, 0), enc_i('h08, 8, 8, 4),
              enc_i('h05, 8, 17, -3)};
        assert_reset();
        load_prog(p);
        release_reset();
        run(20);
        assert_reset();
        for (int a = 0; a <= 20; a += 4) expect_val(2, a, 32'hFEFEFEFE, "keep_fe");
        release_reset();
        run(4);
        expect_val(1, 16, 32'hFEFEFEFE, "fill_s0");
        expect_val(1, 17, 32'd64, "fill_s1");
        expect_val(1, 8, 32'd0, "fill_t0");
        run(48);
        for (int a = 0; a < 64; a += 4) expect_val(2, a, 32'hFEFEFEFE, "fill_fe");
        expect_val(1, 8, 32'd64, "fill_end");
        run(4);

        // Load/store big-endian word.
        p = '{enc_i('h0F, 0, 9, 'h1122), enc_i('h0D, 9, 9, 'h3344),
              enc_i('h2B, 0, 9, 8), enc_i('h23, 0, 10, 8)};
        assert_reset();
        load_prog(p);
        release_reset();
        run(4);
        expect_val(2, 8, 32'h11223344, "sw_word");
        expect_val(1, 10, 32'h11223344, "lw_word");

        // ALU corner cases.
        p = '{enc_i('h08, 0, 9, -1), enc_r('h2B, 0, 9, 10, 0),
              enc_r('h2A, 0, 9, 11, 0), enc_i('h0F, 0, 12, 'h8000),
              enc_r('h03, 0, 12, 13, 4), enc_r('h27, 0, 0, 14, 0)};
        assert_reset();
        load_prog(p);
        release_reset();
        run(6);
        expect_val(1, 9, 32'hFFFFFFFF, "addi_m1");
        expect_val(1, 10, 32'd1, "sltu");
        expect_val(1, 11, 32'd0, "slt");
        expect_val(1, 13, 32'hF8000000, "sra");
        expect_val(1, 14, 32'hFFFFFFFF, "nor");

        // Control flow: untaken beq, jal/jr round trip, write to $0.
        p = {};
        for (int i = 0; i < 18; i++) p.push_back(32'h0);
        p[0]  = enc_i('h08, 0, 9, 5);
        p[1]  = enc_i('h04, 0, 9, 4);
        p[2]  = enc_j('h03, 'h40 >> 2);
        p[3]  = enc_i('h08, 0, 10, 9);
        p[16] = enc_i('h08, 0, 0, 7);
        p[17] = enc_r('h08, 31, 0, 0, 0);
        assert_reset();
        load_prog(p);
        release_reset();
        run(2);
        expect_val(0, 0, 32'h8, "beq_nt");
        run(1);
        expect_val(0, 0, 32'h40, "jal_pc");
        expect_val(1, 31, 32'hC, "jal_ra");
        run(3);
        expect_val(0, 0, 32'h10, "jr_ret");
        expect_val(1, 0, 32'h0, "r0");
        expect_val(1, 10, 32'd9, "after_ret");

        // Random programs against the model.
        for (int t = 0; t < 8; t++) begin
            p = {};
            for (int i = 0; i < 64; i++) p.push_back(rand_ins());
            assert_reset();
            load_prog(p);
            release_reset();
            run(100);
            for (int i = 0; i < 32; i++) expect_val(1, i, rf[i], "final_reg");
        end

        @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending want 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
